// File: rtl/qpp_job_arbiter.sv
// Round-robin arbiter sharing one QPP index generator between several requesters.
// Accepts one (f1, f2, k) job at a time, forwards the result vector to its owner and checks framing.
module qpp_job_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 2,
  localparam int IW        = $clog2(NUM_REQ)
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] s_f1_tdata,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] s_f2_tdata,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] s_k_tdata,
  input  logic [NUM_REQ-1:0]            s_k_tvalid,
  output logic [NUM_REQ-1:0]            s_k_tready,
  output logic [NUM_REQ-1:0]            m_ind_tvalid,
  output logic [DATA_WIDTH-1:0]         m_ind_tdata,
  output logic                          m_ind_tuser,
  output logic                          m_ind_tlast,
  input  logic [NUM_REQ-1:0]            m_ind_tready,
  output logic [DATA_WIDTH-1:0]         g_f1_tdata,
  output logic [DATA_WIDTH-1:0]         g_f2_tdata,
  output logic [DATA_WIDTH-1:0]         g_k_tdata,
  output logic                          g_k_tvalid,
  input  logic                          g_k_tready,
  input  logic                          g_ind_tvalid,
  input  logic                          g_ind_tuser,
  input  logic                          g_ind_tlast,
  input  logic [DATA_WIDTH-1:0]         g_ind_tdata,
  output logic                          g_ind_tready,
  output logic [IW-1:0]                 owner,
  output logic                          busy,
  output logic                          err
);

  // state  | meaning
  // IDLE   | searching requesters from rr_ptr, accepting one job
  // ISSUE  | presenting latched constants to the generator
  // STREAM | passing the generator's vector through to the owner
  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_STREAM} state_t;

  state_t                  state, state_nxt;
  logic [IW-1:0]           rr_ptr, rr_nxt;
  logic [IW-1:0]           win;
  logic                    win_valid;
  logic                    accept;
  logic                    g_ind_hs;
  logic                    frame_err;
  logic [DATA_WIDTH-1:0]   sel_f1, sel_f2, sel_k;
  logic [DATA_WIDTH-1:0]   beat_cnt, beat_nxt;
  logic                    err_q;
  int                      idx;

  // first requesting index at or above rr_ptr, wrapping
  always_comb begin
    win       = '0;
    win_valid = 1'b0;
    idx       = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!win_valid && s_k_tvalid[idx]) begin
        win_valid = 1'b1;
        win       = IW'(idx);
      end
    end
  end

  always_comb begin
    sel_f1 = s_f1_tdata[int'(win)*DATA_WIDTH +: DATA_WIDTH];
    sel_f2 = s_f2_tdata[int'(win)*DATA_WIDTH +: DATA_WIDTH];
    sel_k  = s_k_tdata[int'(win)*DATA_WIDTH +: DATA_WIDTH];
    rr_nxt = (int'(win) == NUM_REQ - 1) ? '0 : win + IW'(1);
  end

  assign accept   = (state == ST_IDLE) && win_valid && aresetn;
  assign g_ind_hs = (state == ST_STREAM) && g_ind_tvalid && g_ind_tready;
  assign beat_nxt = beat_cnt + DATA_WIDTH'(1);
  assign frame_err = ((beat_cnt == '0) ? !g_ind_tuser : g_ind_tuser) ||
                     (g_ind_tlast && (beat_nxt != g_k_tdata));

  always_ff @(posedge aclk) begin
    if (!aresetn) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (accept && (sel_k != '0)) state_nxt = ST_ISSUE;
      ST_ISSUE:  if (g_k_tready)              state_nxt = ST_STREAM;
      ST_STREAM: if (g_ind_hs && g_ind_tlast) state_nxt = ST_IDLE;
      default:                                state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    s_k_tready   = '0;
    m_ind_tvalid = '0;
    m_ind_tdata  = '0;
    m_ind_tuser  = 1'b0;
    m_ind_tlast  = 1'b0;
    g_ind_tready = 1'b0;
    g_k_tvalid   = (state == ST_ISSUE);
    busy         = (state != ST_IDLE);
    if (accept) s_k_tready[win] = 1'b1;
    if (state == ST_STREAM) begin
      m_ind_tvalid[owner] = g_ind_tvalid;
      m_ind_tdata         = g_ind_tdata;
      m_ind_tuser         = g_ind_tuser;
      m_ind_tlast         = g_ind_tlast;
      g_ind_tready        = m_ind_tready[owner];
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      g_f1_tdata <= '0;
      g_f2_tdata <= '0;
      g_k_tdata  <= '0;
      owner      <= '0;
      rr_ptr     <= '0;
      beat_cnt   <= '0;
      err_q      <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (accept) begin
        g_f1_tdata <= sel_f1;
        g_f2_tdata <= sel_f2;
        g_k_tdata  <= sel_k;
        owner      <= win;
        rr_ptr     <= rr_nxt;
        if (sel_k == '0) err_q <= 1'b1;
      end
      if ((state == ST_ISSUE) && g_k_tready) beat_cnt <= '0;
      if (g_ind_hs) begin
        beat_cnt <= beat_nxt;
        if (frame_err) err_q <= 1'b1;
      end
    end
  end

  assign err = err_q;

endmodule

// File: doc/qpp_job_arbiter.md
# qpp_job_arbiter

Shares one QPP index generator between `NUM_REQ` requesters. The generator takes a constant triple (f1, f2, k) on a valid/ready channel and returns a k-beat index vector framed by `tuser` (start of vector) and `tlast` (end of vector). The arbiter accepts one constant triple at a time from the requesters in round-robin order, issues it to the generator, and routes the resulting vector back to the requester that owns the job. It also checks vector framing and length. It sits between the testbench/host-side requesters and the generator.

## Interface

Parameters:
- `DATA_WIDTH`, 32, width of f1/f2/k and of index data.
- `NUM_REQ`, 2, number of requesters (≥2). `IW = $clog2(NUM_REQ)`.

Ports:
- `aclk`  in  1  clock, all logic on rising edge.
- `aresetn`  in  1  synchronous, active-low reset.
- `s_f1_tdata`  in  NUM_REQ*DATA_WIDTH  per-requester f1. Slice i belongs to requester i.
- `s_f2_tdata`  in  NUM_REQ*DATA_WIDTH  per-requester f2.
- `s_k_tdata`  in  NUM_REQ*DATA_WIDTH  per-requester k (vector length).
- `s_k_tvalid`  in  NUM_REQ  job request.
- `s_k_tready`  out  NUM_REQ  job accepted; one-hot or zero.
- `m_ind_tvalid`  out  NUM_REQ  result valid, only the owner's bit.
- `m_ind_tdata`  out  DATA_WIDTH  shared result data.
- `m_ind_tuser`  out  1  shared start-of-vector.
- `m_ind_tlast`  out  1  shared end-of-vector.
- `m_ind_tready`  in  NUM_REQ  per-requester result ready.
- `g_f1_tdata`, `g_f2_tdata`, `g_k_tdata`  out  DATA_WIDTH each  constants to generator, registered.
- `g_k_tvalid`  out  1; `g_k_tready`  in  1  generator constant channel.
- `g_ind_tvalid`, `g_ind_tuser`, `g_ind_tlast`  in  1; `g_ind_tdata`  in  DATA_WIDTH  generator result stream.
- `g_ind_tready`  out  1.
- `owner`  out  IW  index of the current job owner.
- `busy`  out  1  high in any state other than IDLE.
- `err`  out  1  one-cycle pulse on a framing or length error.

## Operation

- FSM states: IDLE, ISSUE, STREAM.
- IDLE:
  - Search `s_k_tvalid` starting at `rr_ptr` and wrapping upward. The first set bit wins.
  - Drive `s_k_tready[win]=1` combinationally in the same cycle; the handshake completes on that edge.
  - Latch f1, f2 and k of the winner into the `g_*_tdata` registers and latch `owner<=win`.
  - If the latched k≠0, go to ISSUE.
  - If k==0, pulse `err` next cycle and stay in IDLE.
  - In both cases set `rr_ptr<=(win+1) mod NUM_REQ`.
- ISSUE:
  - `g_k_tvalid=1` with stable constants.
  - On `g_k_tvalid & g_k_tready`, clear the beat counter and go to STREAM.
- STREAM:
  - Pure combinational pass-through: `m_ind_tvalid[owner]=g_ind_tvalid`, `g_ind_tready=m_ind_tready[owner]`, and data/user/last copied from the generator.
  - All non-owner `m_ind_tvalid` bits are 0.
  - Beat counter (DATA_WIDTH bits) increments on each generator handshake.
  - On the handshake with `g_ind_tlast=1`, go to IDLE.
- Error checks (each pulses `err` on the cycle after the offending handshake; the job still completes normally):
  - First beat has `tuser=0`.
  - A later beat has `tuser=1`.
  - `tlast` arrives on a beat whose count+1 ≠ k.
- Requests arriving while busy are held off: `s_k_tready` stays 0. Requesters keep `s_k_tvalid` and their data stable until accepted.

## Timing

- Reset values:
  - `s_k_tready=0`, `m_ind_tvalid=0`, `g_k_tvalid=0`, `g_ind_tready=0`.
  - `g_*_tdata=0`, `m_ind_tdata/tuser/tlast=0`.
  - `owner=0`, `busy=0`, `err=0`, `rr_ptr=0`, state=IDLE.
- Acceptance edge T (IDLE): `g_k_tvalid` and `busy` are high from T+1.
- Constant hand-off to the generator occurs no earlier than T+1.
- Results are forwarded with zero added latency and no buffering.
- After the tlast handshake at edge E, state is IDLE at E+1. The next acceptance can occur at E+1, so there is one dead cycle between jobs.
- Reset asserted mid-operation:
  - All state returns to reset values on the next edge.
  - The partial vector is abandoned; no `err` is generated.
  - The generator shares `aresetn`.

## Test plan

- Single job, requester 0: f1=3, f2=10, k=40 → one `s_k_tready[0]` pulse, `g_k_tvalid` from the next cycle, 40 beats on `m_ind_tvalid[0]` only, tuser on beat 0, tlast on beat 39, `err` never set.
- Both requesters valid at once from reset: r0 (k=8), r1 (k=16) → r0 served first, then r1. Then with both re-requesting → r0 again (rr_ptr has wrapped), never the same requester twice while the other waits.
- Backpressure: random `m_ind_tready[owner]` low 50% of the time → `g_ind_tready` mirrors it, no beats dropped or duplicated, other requester's `m_ind_tvalid` stays 0.
- Framing errors, injected by the generator model (k=8):
  - tlast on beat 5 → `err` pulse one cycle after beat 5, FSM back in IDLE.
  - Missing tuser on beat 0 → `err` pulse.
- k=0 request → accepted, `err` pulse, no `g_k_tvalid`, `busy` stays 0.
- `aresetn` low for one cycle at beat 10 of a k=40 job → all outputs at reset values next cycle, new job accepted afterwards normally.
